// File: rtl/hdmi_serdes_seq_ctrl.sv
// hdmi_serdes_seq_ctrl
// Power-up and recovery sequencer for the TMDS 10:1 serializer lanes.
// The MMCM lock is synchronised, then qualified for LOCK_WAIT cycles. The
// serializers are held in reset, released, and allowed to settle. They are
// then flushed with IDLE_WORD, and finally encoder symbols pass through.
// Losing lock in any active state returns the block to IDLE on the next
// edge and bumps a saturating loss counter.
//
// Handshake: there is no flow control. ready is a level that is high only
// while the block is in RUN. tmds_out carries valid pixel symbols exactly
// when ready is high, and IDLE_WORD on every lane otherwise.
module hdmi_serdes_seq_ctrl #(
    parameter int                DATA_W     = 10,
    parameter int                LANES      = 3,
    parameter int                LOCK_WAIT  = 64,
    parameter int                RST_CYCLES = 16,
    parameter int                SETTLE_CYC = 8,
    parameter int                FLUSH_CYC  = 4,
    parameter logic [DATA_W-1:0] IDLE_WORD  = 10'b1101010100,
    parameter int                CNT_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pll_locked,
    input  logic [LANES*DATA_W-1:0]   tmds_in,
    output logic [LANES*DATA_W-1:0]   tmds_out,
    output logic                      ser_rst_n,
    output logic                      ser_en,
    output logic                      ready,
    output logic [2:0]                state_o,
    output logic [CNT_W-1:0]          lock_loss_cnt
);

    // One timer is shared by all phases, so it is sized for the longest one.
    localparam int MAX_AB  = (LOCK_WAIT > RST_CYCLES) ? LOCK_WAIT : RST_CYCLES;
    localparam int MAX_CD  = (SETTLE_CYC > FLUSH_CYC) ? SETTLE_CYC : FLUSH_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TMR_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

    localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_WAIT - 1);
    localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] FLUSH_LAST  = TMR_W'(FLUSH_CYC - 1);

    localparam logic [LANES*DATA_W-1:0] IDLE_ALL = {LANES{IDLE_WORD}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_SETTLE = 3'd2,
        S_FLUSH  = 3'd3,
        S_RUN    = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_nx;
    logic             loss;
    logic             sync1;
    logic             lock_s;

    assign state_o = state;

    // Two-flop synchronizer for the asynchronous MMCM lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= pll_locked;
            lock_s <= sync1;
        end
    end

    // Next-state and timer decode. A lost lock beats any timer expiry.
    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        loss     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!lock_s) begin
                    tmr_nx = '0;
                end else if (tmr == LOCK_LAST) begin
                    state_nx = S_RESET;
                    tmr_nx   = '0;
                end else begin
                    tmr_nx = tmr + 1'b1;
                end
            end
            S_RESET: begin
                if (!lock_s) begin
                    state_nx = S_IDLE;
                    tmr_nx   = '0;
                    loss     = 1'b1;
                end else if (tmr == RST_LAST) begin
                    state_nx = S_SETTLE;
                    tmr_nx   = '0;
                end else begin
                    tmr_nx = tmr + 1'b1;
                end
            end
            S_SETTLE: begin
                if (!lock_s) begin
                    state_nx = S_IDLE;
                    tmr_nx   = '0;
                    loss     = 1'b1;
                end else if (tmr == SETTLE_LAST) begin
                    state_nx = S_FLUSH;
                    tmr_nx   = '0;
                end else begin
                    tmr_nx = tmr + 1'b1;
                end
            end
            S_FLUSH: begin
                if (!lock_s) begin
                    state_nx = S_IDLE;
                    tmr_nx   = '0;
                    loss     = 1'b1;
                end else if (tmr == FLUSH_LAST) begin
                    state_nx = S_RUN;
                    tmr_nx   = '0;
                end else begin
                    tmr_nx = tmr + 1'b1;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_nx = S_IDLE;
                    tmr_nx   = '0;
                    loss     = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                tmr_nx   = '0;
            end
        endcase
    end

    // State, timer and outputs. The outputs are decoded from the next state,
    // so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            tmr           <= '0;
            ser_rst_n     <= 1'b0;
            ser_en        <= 1'b0;
            ready         <= 1'b0;
            tmds_out      <= IDLE_ALL;
            lock_loss_cnt <= '0;
        end else begin
            state     <= state_nx;
            tmr       <= tmr_nx;
            ser_rst_n <= (state_nx != S_IDLE) && (state_nx != S_RESET);
            ser_en    <= (state_nx == S_FLUSH) || (state_nx == S_RUN);
            ready     <= (state_nx == S_RUN);
            tmds_out  <= (state_nx == S_RUN) ? tmds_in : IDLE_ALL;
            if (loss && (lock_loss_cnt != {CNT_W{1'b1}})) begin
                lock_loss_cnt <= lock_loss_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_serdes_seq_ctrl.sv
// Directed bench for hdmi_serdes_seq_ctrl with default parameters.
// Edge numbering: edge 1 is the first rising clock edge after rst_n is released.
module tb_hdmi_serdes_seq_ctrl;

    localparam logic [9:0]  IDLE_W   = 10'b1101010100;
    localparam logic [29:0] IDLE_ALL = {IDLE_W, IDLE_W, IDLE_W};

    logic        clk;
    logic        rst_n;
    logic        pll_locked;
    logic [29:0] tmds_in;
    logic [29:0] tmds_out;
    logic        ser_rst_n;
    logic        ser_en;
    logic        ready;
    logic [2:0]  state_o;
    logic [7:0]  lock_loss_cnt;

    int total;
    int bad;

    logic [29:0] vec [6];

    hdmi_serdes_seq_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .tmds_in       (tmds_in),
        .tmds_out      (tmds_out),
        .ser_rst_n     (ser_rst_n),
        .ser_en        (ser_en),
        .ready         (ready),
        .state_o       (state_o),
        .lock_loss_cnt (lock_loss_cnt)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then sample 1 time unit after the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_cnt;
        total = 0;
        bad = 0;
        vec[0] = {10'h2AA, 10'h155, 10'h3FF};
        vec[1] = {10'h155, 10'h3FF, 10'h2AA};
        vec[2] = {10'h3FF, 10'h2AA, 10'h155};
        vec[3] = 30'h0000_0000;
        vec[4] = 30'h3FFF_FFFF;
        vec[5] = {10'h001, 10'h200, 10'h0F0};

        rst_n      = 1'b0;
        pll_locked = 1'b1;
        tmds_in    = {10'h0AB, 10'h0CD, 10'h0EF};
        step(2);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_ser_rst_n", 32'(ser_rst_n), 32'd0);
        check("rst_ser_en", 32'(ser_en), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_tmds_out", 32'(tmds_out), 32'(IDLE_ALL));
        check("rst_loss_cnt", 32'(lock_loss_cnt), 32'd0);

        // Power-up: RESET at edge 66, SETTLE at 82, FLUSH at 90, RUN at 94
        @(negedge clk) rst_n = 1'b1;
        step(65);
        check("pu_idle_65", 32'(state_o), 32'd0);
        step(1);
        check("pu_reset_66", 32'(state_o), 32'd1);
        step(15);
        check("pu_serrst_81", 32'(ser_rst_n), 32'd0);
        step(1);
        check("pu_serrst_82", 32'(ser_rst_n), 32'd1);
        check("pu_settle_82", 32'(state_o), 32'd2);
        check("pu_en_82", 32'(ser_en), 32'd0);
        step(7);
        check("pu_en_89", 32'(ser_en), 32'd0);
        step(1);
        check("pu_en_90", 32'(ser_en), 32'd1);
        check("pu_flush_90", 32'(state_o), 32'd3);
        check("pu_idleword_90", 32'(tmds_out), 32'(IDLE_ALL));
        step(3);
        check("pu_ready_93", 32'(ready), 32'd0);
        check("pu_idleword_93", 32'(tmds_out), 32'(IDLE_ALL));
        tmds_in = vec[0];
        step(1);
        check("pu_ready_94", 32'(ready), 32'd1);
        check("pu_run_94", 32'(state_o), 32'd4);
        check("run_first_word", 32'(tmds_out), 32'(vec[0]));

        // Pass-through stream, one-cycle latency
        for (int i = 1; i < 6; i++) begin
            tmds_in = vec[i];
            step(1);
            check("run_stream", 32'(tmds_out), 32'(vec[i]));
        end
        tmds_in = {10'h111, 10'h222, 10'h333};
        #1;
        check("run_no_comb_path", 32'(tmds_out), 32'(vec[5]));

        // Lock loss in RUN: visible on the third edge after the drop
        pll_locked = 1'b0;
        step(2);
        check("loss_ready_still", 32'(ready), 32'd1);
        step(1);
        check("loss_ready", 32'(ready), 32'd0);
        check("loss_en", 32'(ser_en), 32'd0);
        check("loss_serrst", 32'(ser_rst_n), 32'd0);
        check("loss_tmds", 32'(tmds_out), 32'(IDLE_ALL));
        check("loss_state", 32'(state_o), 32'd0);
        check("loss_cnt_1", 32'(lock_loss_cnt), 32'd1);

        // Relock, then a one-cycle glitch at IDLE count 40 restarts qualification
        step(2);
        pll_locked = 1'b1;
        step(42);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(23);
        check("glitch_no_early_reset", 32'(state_o), 32'd0);
        step(42);
        check("glitch_idle_65", 32'(state_o), 32'd0);
        step(1);
        check("glitch_reset_66", 32'(state_o), 32'd1);
        check("glitch_cnt_kept", 32'(lock_loss_cnt), 32'd1);
        step(16);
        check("glitch_settle", 32'(state_o), 32'd2);
        check("glitch_serrst", 32'(ser_rst_n), 32'd1);

        // Asynchronous reset in SETTLE
        step(1);
        rst_n = 1'b0;
        #1;
        check("async_state", 32'(state_o), 32'd0);
        check("async_serrst", 32'(ser_rst_n), 32'd0);
        check("async_en", 32'(ser_en), 32'd0);
        check("async_ready", 32'(ready), 32'd0);
        step(2);
        check("async_hold_state", 32'(state_o), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step(93);
        check("restart_ready_93", 32'(ready), 32'd0);
        step(1);
        check("restart_ready_94", 32'(ready), 32'd1);

        pll_locked = 1'b0;
        step(3);
        check("restart_loss_cnt", 32'(lock_loss_cnt), 32'd1);

        // Repeated losses from RESET until the counter saturates
        for (int i = 1; i <= 299; i++) begin
            pll_locked = 1'b1;
            step(66);
            if (i == 1) check("sat_in_reset", 32'(state_o), 32'd1);
            pll_locked = 1'b0;
            step(3);
            exp_cnt = (i + 1 > 255) ? 255 : i + 1;
            if (i == 1 || i == 253 || i == 254 || i == 255 || i == 299)
                check("sat_cnt", 32'(lock_loss_cnt), 32'(exp_cnt));
        end
        check("sat_state_idle", 32'(state_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
